// File: rtl/ex_mc.sv
// Execute stage with single-cycle ALU, an iterative multiply/divide unit and
// memory request formation (enable, size, alignment check).
//
// Handshake: decode presents an instruction with i_valid; it is captured on an
// edge where clr=0, stall=0 and o_busy=0, otherwise decode must hold it.
// o_valid marks a finished instruction; downstream freezes it with stall.
module ex_mc #(
    parameter int WORD_W      = 32,
    parameter int REG_IDX_W   = 5,
    parameter int MD_EN       = 1,
    parameter int ALU_OP_W    = 4,
    parameter int MEM_OP_W    = 3,
    parameter int MEM_COUNT_W = 3,
    parameter int DEST_SRC_W  = 2
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   stall,
    input  logic                   i_valid,
    input  logic [WORD_W-1:0]      i_pc,
    input  logic [ALU_OP_W-1:0]    i_alu_op,
    input  logic [2:0]             i_md_op,
    input  logic [WORD_W-1:0]      i_alu_data_a,
    input  logic [WORD_W-1:0]      i_alu_data_b,
    input  logic [WORD_W-1:0]      i_wr_data,
    input  logic [MEM_OP_W-1:0]    i_mem_op,
    input  logic [DEST_SRC_W-1:0]  i_dest_src,
    input  logic [REG_IDX_W-1:0]   i_dest_reg,
    output logic                   o_busy,
    output logic                   o_valid,
    output logic [WORD_W-1:0]      o_pc,
    output logic [DEST_SRC_W-1:0]  o_dest_src,
    output logic [REG_IDX_W-1:0]   o_dest_reg,
    output logic [WORD_W-1:0]      o_alu_eval,
    output logic                   o_mem_req_en,
    output logic                   o_mem_req_wr_en,
    output logic [WORD_W-1:0]      o_mem_req_addr,
    output logic [WORD_W-1:0]      o_mem_req_wr_data,
    output logic [MEM_COUNT_W-1:0] o_mem_req_count,
    output logic                   o_misalign,
    output logic [1:0]             o_md_state
);

    localparam logic [ALU_OP_W-1:0] ALU_ADD    = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] ALU_SUB    = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] ALU_AND    = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] ALU_OR     = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] ALU_XOR    = ALU_OP_W'(4);
    localparam logic [ALU_OP_W-1:0] ALU_SLL    = ALU_OP_W'(5);
    localparam logic [ALU_OP_W-1:0] ALU_SRL    = ALU_OP_W'(6);
    localparam logic [ALU_OP_W-1:0] ALU_SRA    = ALU_OP_W'(7);
    localparam logic [ALU_OP_W-1:0] ALU_SLT    = ALU_OP_W'(8);
    localparam logic [ALU_OP_W-1:0] ALU_SLTU   = ALU_OP_W'(9);
    localparam logic [ALU_OP_W-1:0] ALU_PASS_B = ALU_OP_W'(10);

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MUL   = 3'd1;
    localparam logic [2:0] MD_MULHU = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_REMU  = 3'd4;
    localparam logic [2:0] MD_DIV   = 3'd5;
    localparam logic [2:0] MD_REM   = 3'd6;

    localparam logic [MEM_OP_W-1:0]   MEM_NOP        = MEM_OP_W'(0);
    localparam logic [DEST_SRC_W-1:0] DEST_SRC_NONE  = DEST_SRC_W'(0);

    localparam int SH_W  = $clog2(WORD_W);
    localparam int CNT_W = $clog2(WORD_W);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

    // Stage register
    logic                  r_valid_q, r_valid_d;
    logic [WORD_W-1:0]     r_pc_q, r_pc_d;
    logic [ALU_OP_W-1:0]   r_alu_op_q, r_alu_op_d;
    logic [2:0]            r_md_op_q, r_md_op_d;
    logic [WORD_W-1:0]     r_a_q, r_a_d;
    logic [WORD_W-1:0]     r_b_q, r_b_d;
    logic [WORD_W-1:0]     r_wr_data_q, r_wr_data_d;
    logic [MEM_OP_W-1:0]   r_mem_op_q, r_mem_op_d;
    logic [DEST_SRC_W-1:0] r_dest_src_q, r_dest_src_d;
    logic [REG_IDX_W-1:0]  r_dest_reg_q, r_dest_reg_d;

    // Multiply/divide engine
    md_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] hi_q, hi_d;
    logic [WORD_W-1:0] lo_q, lo_d;
    logic [WORD_W-1:0] dv_q, dv_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;

    logic              load;
    logic              md_pending;
    logic              md_is_mul;
    logic              md_is_signed;
    logic              a_neg;
    logic              b_neg;
    logic [2:0]        md_in;
    logic [WORD_W:0]   mul_sum;
    logic [WORD_W:0]   rem_sh;
    logic [WORD_W:0]   rem_diff;
    logic [WORD_W-1:0] md_result;
    logic [WORD_W-1:0] alu_result;
    logic [SH_W-1:0]   sh;
    logic [1:0]        mem_size;
    logic              mem_mis;
    logic [MEM_COUNT_W-1:0] mem_count;

    assign md_pending   = (MD_EN != 0) && r_valid_q && (r_md_op_q != MD_NONE);
    assign o_busy       = (MD_EN != 0) && ((md_pending && state_q == ST_IDLE) || state_q == ST_RUN);
    assign load         = !stall && !o_busy;
    assign md_is_mul    = (r_md_op_q == MD_MUL) || (r_md_op_q == MD_MULHU);
    assign md_is_signed = (r_md_op_q == MD_DIV) || (r_md_op_q == MD_REM);
    assign a_neg        = r_a_q[WORD_W-1];
    assign b_neg        = r_b_q[WORD_W-1];
    assign md_in        = (MD_EN == 0 || i_md_op == 3'd7) ? MD_NONE : i_md_op;

    always_comb begin
        r_valid_d    = r_valid_q;
        r_pc_d       = r_pc_q;
        r_alu_op_d   = r_alu_op_q;
        r_md_op_d    = r_md_op_q;
        r_a_d        = r_a_q;
        r_b_d        = r_b_q;
        r_wr_data_d  = r_wr_data_q;
        r_mem_op_d   = r_mem_op_q;
        r_dest_src_d = r_dest_src_q;
        r_dest_reg_d = r_dest_reg_q;
        if (load) begin
            r_valid_d    = i_valid;
            r_pc_d       = i_pc;
            r_alu_op_d   = i_alu_op;
            r_md_op_d    = md_in;
            r_a_d        = i_alu_data_a;
            r_b_d        = i_alu_data_b;
            r_wr_data_d  = i_wr_data;
            r_mem_op_d   = i_mem_op;
            r_dest_src_d = i_dest_src;
            r_dest_reg_d = i_dest_reg;
        end
    end

    // Shift-add multiply keeps {hi,lo} as the running product; restoring
    // division keeps the partial remainder in hi and shifts quotient bits into lo.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dv_d      = dv_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dv_q} : '0);
        rem_sh    = {hi_q, lo_q[WORD_W-1]};
        rem_diff  = rem_sh - {1'b0, dv_q};
        case (state_q)
            ST_IDLE: begin
                if (md_pending) begin
                    state_d   = ST_RUN;
                    cnt_d     = '0;
                    hi_d      = '0;
                    lo_d      = (md_is_signed && a_neg) ? -r_a_q : r_a_q;
                    dv_d      = (md_is_signed && b_neg) ? -r_b_q : r_b_q;
                    neg_quo_d = md_is_signed && (a_neg ^ b_neg);
                    neg_rem_d = md_is_signed && a_neg;
                end
            end
            ST_RUN: begin
                if (md_is_mul) begin
                    {hi_d, lo_d} = {mul_sum, lo_q[WORD_W-1:1]};
                end else if (!rem_diff[WORD_W]) begin
                    hi_d = rem_diff[WORD_W-1:0];
                    lo_d = {lo_q[WORD_W-2:0], 1'b1};
                end else begin
                    hi_d = rem_sh[WORD_W-1:0];
                    lo_d = {lo_q[WORD_W-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WORD_W - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (load) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_valid_q    <= 1'b0;
            r_pc_q       <= '0;
            r_alu_op_q   <= ALU_ADD;
            r_md_op_q    <= MD_NONE;
            r_a_q        <= '0;
            r_b_q        <= '0;
            r_wr_data_q  <= '0;
            r_mem_op_q   <= MEM_NOP;
            r_dest_src_q <= DEST_SRC_NONE;
            r_dest_reg_q <= '0;
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            dv_q         <= '0;
            neg_quo_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
        end else begin
            r_valid_q    <= r_valid_d;
            r_pc_q       <= r_pc_d;
            r_alu_op_q   <= r_alu_op_d;
            r_md_op_q    <= r_md_op_d;
            r_a_q        <= r_a_d;
            r_b_q        <= r_b_d;
            r_wr_data_q  <= r_wr_data_d;
            r_mem_op_q   <= r_mem_op_d;
            r_dest_src_q <= r_dest_src_d;
            r_dest_reg_q <= r_dest_reg_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            dv_q         <= dv_d;
            neg_quo_q    <= neg_quo_d;
            neg_rem_q    <= neg_rem_d;
        end
    end

    // Divide-by-zero is overridden; signed overflow falls out of the magnitude path.
    always_comb begin
        case (r_md_op_q)
            MD_MUL:   md_result = lo_q;
            MD_MULHU: md_result = hi_q;
            MD_DIVU, MD_DIV: begin
                if (r_b_q == '0) md_result = '1;
                else             md_result = neg_quo_q ? -lo_q : lo_q;
            end
            MD_REMU, MD_REM: begin
                if (r_b_q == '0) md_result = r_a_q;
                else             md_result = neg_rem_q ? -hi_q : hi_q;
            end
            default:  md_result = lo_q;
        endcase
    end

    assign sh = r_b_q[SH_W-1:0];

    always_comb begin
        case (r_alu_op_q)
            ALU_ADD:    alu_result = r_a_q + r_b_q;
            ALU_SUB:    alu_result = r_a_q - r_b_q;
            ALU_AND:    alu_result = r_a_q & r_b_q;
            ALU_OR:     alu_result = r_a_q | r_b_q;
            ALU_XOR:    alu_result = r_a_q ^ r_b_q;
            ALU_SLL:    alu_result = r_a_q << sh;
            ALU_SRL:    alu_result = r_a_q >> sh;
            ALU_SRA:    alu_result = $unsigned($signed(r_a_q) >>> sh);
            ALU_SLT:    alu_result = {{(WORD_W-1){1'b0}}, ($signed(r_a_q) < $signed(r_b_q))};
            ALU_SLTU:   alu_result = {{(WORD_W-1){1'b0}}, (r_a_q < r_b_q)};
            ALU_PASS_B: alu_result = r_b_q;
            default:    alu_result = r_a_q + r_b_q;
        endcase
    end

    assign o_valid    = r_valid_q && !o_busy;
    assign o_alu_eval = (state_q == ST_DONE) ? md_result : alu_result;
    assign o_pc       = r_pc_q;
    assign o_dest_src = r_dest_src_q;
    assign o_dest_reg = r_dest_reg_q;
    assign o_md_state = state_q;

    // mem_op[1:0] is the access size (0 = none), mem_op[2] selects a write.
    assign mem_size = r_mem_op_q[1:0];

    always_comb begin
        mem_count = '0;
        mem_mis   = 1'b0;
        case (mem_size)
            2'd1: mem_count = MEM_COUNT_W'(1);
            2'd2: begin
                mem_count = MEM_COUNT_W'(2);
                mem_mis   = o_alu_eval[0];
            end
            2'd3: begin
                mem_count = MEM_COUNT_W'(4);
                mem_mis   = (o_alu_eval[1:0] != 2'b00);
            end
            default: mem_count = '0;
        endcase
    end

    assign o_misalign        = o_valid && mem_mis;
    assign o_mem_req_en      = o_valid && (mem_size != 2'd0) && !mem_mis;
    assign o_mem_req_wr_en   = r_mem_op_q[2] && (mem_size != 2'd0);
    assign o_mem_req_count   = mem_count;
    assign o_mem_req_addr    = o_alu_eval;
    assign o_mem_req_wr_data = r_wr_data_q;

endmodule

// File: tb/tb_ex_mc.sv
// Self-checking bench for ex_mc: directed and random ALU, memory and
// multiply/divide instructions against an arithmetic reference model.
module tb_ex_mc;

    localparam int W = 32;

    logic          clk;
    logic          clr;
    logic          stall;
    logic          i_valid;
    logic [W-1:0]  i_pc;
    logic [3:0]    i_alu_op;
    logic [2:0]    i_md_op;
    logic [W-1:0]  i_alu_data_a;
    logic [W-1:0]  i_alu_data_b;
    logic [W-1:0]  i_wr_data;
    logic [2:0]    i_mem_op;
    logic [1:0]    i_dest_src;
    logic [4:0]    i_dest_reg;
    logic          o_busy;
    logic          o_valid;
    logic [W-1:0]  o_pc;
    logic [1:0]    o_dest_src;
    logic [4:0]    o_dest_reg;
    logic [W-1:0]  o_alu_eval;
    logic          o_mem_req_en;
    logic          o_mem_req_wr_en;
    logic [W-1:0]  o_mem_req_addr;
    logic [W-1:0]  o_mem_req_wr_data;
    logic [2:0]    o_mem_req_count;
    logic          o_misalign;
    logic [1:0]    o_md_state;

    int n_cmp;
    int n_fail;
    logic [W-1:0] exp_q[$];

    ex_mc dut (
        .clk(clk), .clr(clr), .stall(stall), .i_valid(i_valid), .i_pc(i_pc),
        .i_alu_op(i_alu_op), .i_md_op(i_md_op), .i_alu_data_a(i_alu_data_a),
        .i_alu_data_b(i_alu_data_b), .i_wr_data(i_wr_data), .i_mem_op(i_mem_op),
        .i_dest_src(i_dest_src), .i_dest_reg(i_dest_reg), .o_busy(o_busy),
        .o_valid(o_valid), .o_pc(o_pc), .o_dest_src(o_dest_src), .o_dest_reg(o_dest_reg),
        .o_alu_eval(o_alu_eval), .o_mem_req_en(o_mem_req_en),
        .o_mem_req_wr_en(o_mem_req_wr_en), .o_mem_req_addr(o_mem_req_addr),
        .o_mem_req_wr_data(o_mem_req_wr_data), .o_mem_req_count(o_mem_req_count),
        .o_misalign(o_misalign), .o_md_state(o_md_state)
    );

    // Clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model
    function automatic logic [W-1:0] ref_alu(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
        int sa;
        int sb;
        int amt;
        sa  = a;
        sb  = b;
        amt = int'(b % 32);
        case (op)
            1:  return a - b;
            2:  return a & b;
            3:  return a | b;
            4:  return a ^ b;
            5:  return a << amt;
            6:  return a >> amt;
            7:  return sa >>> amt;
            8:  return (sa < sb) ? 1 : 0;
            9:  return (a < b) ? 1 : 0;
            10: return b;
            default: return a + b;
        endcase
    endfunction

    function automatic logic [W-1:0] ref_md(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint unsigned pa;
        longint unsigned pb;
        longint unsigned p;
        int sa;
        int sb;
        logic ovf;
        pa  = a;
        pb  = b;
        p   = pa * pb;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            1: return p[31:0];
            2: return p[63:32];
            3: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4: return (b == 0) ? a : a % b;
            5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return 32'h8000_0000;
                return sa / sb;
            end
            6: begin
                if (b == 0) return a;
                if (ovf)    return 32'h0;
                return sa % sb;
            end
            default: return a + b;
        endcase
    endfunction

    int bytes_tab[8] = '{0, 1, 2, 4, 0, 1, 2, 4};
    int wr_tab[8]    = '{0, 0, 0, 0, 0, 1, 1, 1};

    // Scoreboard compare
    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drivers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int alu, input int md, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int mem, input logic [W-1:0] wd, input logic [W-1:0] pc, input logic [4:0] rd);
        i_valid      = 1'b1;
        i_alu_op     = 4'(alu);
        i_md_op      = 3'(md);
        i_alu_data_a = a;
        i_alu_data_b = b;
        i_mem_op     = 3'(mem);
        i_wr_data    = wd;
        i_pc         = pc;
        i_dest_reg   = rd;
        i_dest_src   = 2'd1;
    endtask

    task automatic run_alu(input int alu, input int md, input logic [W-1:0] a, input logic [W-1:0] b, input int mem);
        logic [W-1:0] exp;
        logic [W-1:0] pc;
        logic [W-1:0] wd;
        logic [4:0]   rd;
        int           nb;
        logic         mis;
        pc = $urandom;
        wd = $urandom;
        rd = 5'($urandom_range(0, 31));
        exp_q.push_back(ref_alu(alu, a, b));
        drive(alu, md, a, b, mem, wd, pc, rd);
        step();
        i_valid = 1'b0;
        exp = exp_q.pop_front();
        nb  = bytes_tab[mem];
        mis = (nb > 1) && ((exp % nb) != 0);
        chk("alu_eval", o_alu_eval, exp);
        chk("alu_valid", o_valid, 1);
        chk("alu_busy", o_busy, 0);
        chk("alu_pc", o_pc, pc);
        chk("alu_dest_reg", o_dest_reg, rd);
        chk("alu_dest_src", o_dest_src, 1);
        chk("mem_addr", o_mem_req_addr, exp);
        chk("mem_wr_data", o_mem_req_wr_data, wd);
        chk("mem_count", o_mem_req_count, nb);
        chk("mem_wr_en", o_mem_req_wr_en, (nb != 0) ? wr_tab[mem] : 0);
        chk("mem_misalign", o_misalign, mis);
        chk("mem_req_en", o_mem_req_en, (nb != 0) && !mis);
    endtask

    // Leaves the bench in the cycle where the result is presented (DONE).
    task automatic run_md(input int md, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] exp;
        int n;
        exp_q.push_back(ref_md(md, a, b));
        drive(0, md, a, b, 0, 0, $urandom, 5'd3);
        step();
        i_valid = 1'b0;
        chk("md_busy_start", o_busy, 1);
        chk("md_valid_start", o_valid, 0);
        n = 0;
        while (o_busy && n < 200) begin
            step();
            n++;
        end
        exp = exp_q.pop_front();
        chk("md_busy_cycles", n, W + 1);
        chk("md_valid", o_valid, 1);
        chk("md_result", o_alu_eval, exp);
        chk("md_state_done", o_md_state, 2);
        chk("md_mem_en", o_mem_req_en, 0);
    endtask

    // Stimulus
    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        int op;
        n_cmp   = 0;
        n_fail  = 0;
        clr     = 1'b1;
        stall   = 1'b0;
        i_valid = 1'b0;
        i_pc = '0; i_alu_op = '0; i_md_op = '0; i_alu_data_a = '0; i_alu_data_b = '0;
        i_wr_data = '0; i_mem_op = '0; i_dest_src = '0; i_dest_reg = '0;
        step();
        step();
        chk("rst_busy", o_busy, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_alu_eval", o_alu_eval, 0);
        chk("rst_mem_en", o_mem_req_en, 0);
        chk("rst_misalign", o_misalign, 0);
        chk("rst_state", o_md_state, 0);
        clr = 1'b0;

        run_alu(0, 0, 5, 7, 0);

        run_md(1, 32'hFFFF_FFFF, 2);
        run_md(2, 32'hFFFF_FFFF, 2);
        run_md(5, -32'sd7, 2);
        run_md(6, -32'sd7, 2);
        run_md(5, 32'd100, 0);
        run_md(5, 32'h8000_0000, 32'hFFFF_FFFF);
        run_md(6, 32'h8000_0000, 32'hFFFF_FFFF);
        run_md(3, 32'd1234, 0);
        run_md(4, 32'd1234, 0);
        run_md(6, -32'sd9, 0);

        run_alu(0, 0, 32'h1000, 1, 6);
        run_alu(0, 0, 32'h1000, 4, 3);
        run_alu(0, 7, 32'd40, 32'd2, 0);

        // clr while the divider iterates
        drive(0, 3, 32'hDEAD_BEEF, 32'd7, 0, 0, 0, 0);
        step();
        i_valid = 1'b0;
        repeat (11) step();
        chk("clr_pre_state", o_md_state, 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_busy", o_busy, 0);
        chk("clr_valid", o_valid, 0);
        chk("clr_state", o_md_state, 0);
        chk("clr_alu_eval", o_alu_eval, 0);
        run_alu(0, 0, 32'd20, 32'd22, 0);

        // stall holds a finished MD result
        run_md(1, 32'd12345, 32'd678);
        exp = ref_md(1, 32'd12345, 32'd678);
        stall = 1'b1;
        drive(1, 0, 32'd50, 32'd8, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", o_valid, 1);
            chk("stall_result", o_alu_eval, exp);
        end
        stall = 1'b0;
        run_alu(1, 0, 32'd50, 32'd8, 0);

        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 10);
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            run_alu(op, 0, a, b, $urandom_range(0, 7));
        end

        for (int i = 0; i < 16; i++) begin
            op = $urandom_range(1, 6);
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = 0;
            if ($urandom_range(0, 7) == 0) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end
            if ($urandom_range(0, 2) == 0) b = b >> $urandom_range(8, 28);
            run_md(op, a, b);
        end
        run_alu(0, 0, 32'd1, 32'd2, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mc.md
# ex_mc

Parametrised execute stage with an iterative multiply/divide unit. It sits between the decode/register-read stage and the memory stage. It latches one instruction per cycle into its stage register and evaluates single-cycle ALU operations combinationally, as the base execute stage does. Multiply/divide operations run over WORD_W+1 cycles with back-pressure to decode. The stage also forms memory requests with an enable and an alignment check.

## Interface
Parameters:
- WORD_W, 32, datapath width; also the memory address width; power of two, ≥8
- REG_IDX_W, 5, destination register index width
- MD_EN, 1, 1 = multiply/divide unit present; 0 = MD ops execute as MD_NONE

Ports:
- clk  in  1  clock; all state updates on rising edge
- clr  in  1  reset, synchronous, active-high
- stall  in  1  downstream stall; stage register holds when 1
- i_valid  in  1  input slot carries an instruction
- i_pc  in  WORD_W  instruction address
- i_alu_op  in  ALU_OP_W  single-cycle ALU operation (alu_op.vh)
- i_md_op  in  3  0 NONE, 1 MUL, 2 MULHU, 3 DIVU, 4 REMU, 5 DIV, 6 REM; 7 treated as NONE
- i_alu_data_a, i_alu_data_b  in  WORD_W  operands
- i_wr_data  in  WORD_W  store data
- i_mem_op  in  MEM_OP_W  memory operation (mem_codes.vh)
- i_dest_src, i_dest_reg  in  DEST_SRC_W / REG_IDX_W  writeback control
- o_busy  out  1  multi-cycle op in flight; decode must hold and not advance
- o_valid  out  1  stage output is a finished instruction
- o_pc, o_dest_src, o_dest_reg  out  —  registered pass-through
- o_alu_eval  out  WORD_W  ALU result, or MD result
- o_mem_req_en, o_mem_req_wr_en  out  1  request strobe / write select
- o_mem_req_addr, o_mem_req_wr_data  out  WORD_W  address (= o_alu_eval) / store data
- o_mem_req_count  out  MEM_COUNT_W  byte/half/word count
- o_misalign  out  1  half access at odd address, or word access with addr[1:0]≠0

## Operation
- Load: stage register captures all inputs on a clk edge with clr=0, stall=0, o_busy=0. Otherwise it holds.
- FSM states:
  - IDLE → RUN on the edge after a valid MD op is captured. That edge loads operand magnitudes and sets counter=0.
  - RUN: one shift-add (MUL/MULHU) or restoring shift-subtract (DIV*/REM*) step per edge. counter increments. RUN → DONE when counter = WORD_W−1.
  - DONE: applies sign correction for DIV/REM and holds the result. DONE → IDLE on the next load.
- o_busy = (valid MD op captured and state=IDLE and not done) or state=RUN. It is combinational from the registers.
- o_valid = r_valid & ~o_busy.
- Arithmetic:
  - MUL = low WORD_W bits of a·b. MULHU = high WORD_W bits, unsigned.
  - DIV/REM are signed: magnitudes are divided; the quotient is negated if operand signs differ; the remainder takes the dividend's sign.
- Division by zero: DIVU → all ones; DIV → −1; REMU/REM → dividend.
- Signed overflow (most-negative / −1): quotient = most-negative, remainder = 0.
- Memory: o_mem_req_en = o_valid & (mem_op≠NOP) & ~o_misalign.
  - o_mem_req_wr_en is 1 for WR_* only. o_mem_req_count follows the access size. For NOP, count is 0 and wr_en is 0.
  - o_misalign is only asserted for non-NOP ops with o_valid=1.
- MD_EN=0: no FSM; o_busy tied to 0.

## Timing
- Reset: all registers 0, r_mem_op=NOP, r_alu_op=ALU_ADD, dest_src=DEST_SRC_NONE, FSM=IDLE, counter=0.
  - Resulting outputs: o_busy=0, o_valid=0, o_alu_eval=0 (ADD 0+0), o_mem_req_en=0, o_misalign=0.
- Single-cycle op captured at edge k: result valid during cycle k..k+1.
- MD op captured at edge k: o_busy=1 from edge k until edge k+WORD_W+1. DONE is entered at edge k+WORD_W+1, with o_valid=1 and the result on o_alu_eval in that cycle.
  - Total decode hold is WORD_W+1 cycles.
- stall=1 during DONE: result and o_valid hold indefinitely. stall during RUN has no effect on the iteration.
- clr mid-RUN: the operation is abandoned; the state is reset-equivalent on the next cycle.
- Back-to-back MD ops: the second is captured on the edge leaving DONE and starts RUN on the following edge.

## Test plan
- Reset, then ADD a=5, b=7, valid, stall=0 → next cycle o_alu_eval=12, o_valid=1, o_busy=0, o_mem_req_en=0.
- MUL a=0xFFFF_FFFF, b=2 (WORD_W=32) → o_busy high exactly 33 cycles, then o_alu_eval=0xFFFF_FFFE. Repeat with MULHU → 0x0000_0001.
- DIV a=−7, b=2 → −3; REM → −1; DIV b=0 → 0xFFFF_FFFF; DIV 0x8000_0000 / −1 → 0x8000_0000, REM → 0.
- WR_HALF at address 0x1001 → o_misalign=1, o_mem_req_en=0. RD_WORD at 0x1004 → o_mem_req_en=1, wr_en=0, count=WORD.
- Start DIVU, assert clr at RUN cycle 10 → next cycle o_busy=0, o_valid=0; a following ADD completes normally.
- MUL done with stall=1 held 5 cycles → o_alu_eval and o_valid stable. Release stall → next instruction loads on the following edge.
